// File: rtl/vga_stream_out.sv
// vga_stream_out: VGA raster generator and pixel sink for the camera display path.
// Generates hsync/vsync/de from programmable timing and pulls pixels from a
// show-ahead FIFO. Every pixel-rate output is registered one cycle after the
// raster counters so all outputs stay mutually aligned.
// Optional feature: define VGA_TEST_PATTERN_EN to build the colour-bar generator
// selected by test_mode; without it test_mode is ignored.
module vga_stream_out #(
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned H_ACT   = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BP    = 33,
  parameter int unsigned V_ACT   = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned HS_POL  = 0,
  parameter int unsigned VS_POL  = 0,
  parameter int unsigned COLOR_W = 4,
  parameter int unsigned CNT_W   = 12
) (
  input  logic                 pixel_clock,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 test_mode,
  input  logic [3*COLOR_W-1:0] pix_data,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic                 uf_clr,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [COLOR_W-1:0]   r,
  output logic [COLOR_W-1:0]   g,
  output logic [COLOR_W-1:0]   b,
  output logic [CNT_W-1:0]     pix_x,
  output logic [CNT_W-1:0]     pix_y,
  output logic                 frame_start,
  output logic                 underflow
);

  localparam int unsigned H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int unsigned V_TOT = V_SYNC + V_BP + V_ACT + V_FP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_BEG  = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_SYNC + H_BP + H_ACT);
  localparam logic [CNT_W-1:0] V_ACT_BEG  = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_SYNC + V_BP + V_ACT);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  logic [CNT_W-1:0] h_cnt_q, v_cnt_q;
  logic             run_q;
  logic             h_last, v_last, frame_end;
  logic             hs_on, vs_on, act_on;
  logic             test_sel;
  logic             uf_set;
  logic [3*COLOR_W-1:0] bar_rgb;
  logic [3*COLOR_W-1:0] rgb_d;

  logic                 hsync_q, vsync_q, de_q, frame_start_q, underflow_q;
  logic [3*COLOR_W-1:0] rgb_q;
  logic [CNT_W-1:0]     pix_x_q, pix_y_q;

  assign h_last    = (h_cnt_q == H_LAST);
  assign v_last    = (v_cnt_q == V_LAST);
  assign frame_end = h_last & v_last;

  assign hs_on  = (h_cnt_q < H_SYNC_END);
  assign vs_on  = (v_cnt_q < V_SYNC_END);
  assign act_on = (h_cnt_q >= H_ACT_BEG) && (h_cnt_q < H_ACT_END) &&
                  (v_cnt_q >= V_ACT_BEG) && (v_cnt_q < V_ACT_END);

  // Raster counters: h wraps every line, v advances on each h wrap.
  always_ff @(posedge pixel_clock or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else if (h_last) begin
      h_cnt_q <= '0;
      v_cnt_q <= v_last ? '0 : v_cnt_q + CNT_W'(1);
    end else begin
      h_cnt_q <= h_cnt_q + CNT_W'(1);
    end
  end

  // Stream enable is only taken at the frame boundary so frames are never partial.
  always_ff @(posedge pixel_clock or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
    end else if (frame_end) begin
      run_q <= enable;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACT / 8;
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

  logic             test_sel_q;
  logic [CNT_W-1:0] bar_pos_q;
  logic [2:0]       bar_idx_q;

  // Pattern select follows the same frame-boundary sampling as run.
  always_ff @(posedge pixel_clock or negedge rst_n) begin
    if (!rst_n) begin
      test_sel_q <= 1'b0;
    end else if (frame_end) begin
      test_sel_q <= test_mode;
    end
  end

  // Bar counter: position within the current bar, cleared outside active video.
  always_ff @(posedge pixel_clock or negedge rst_n) begin
    if (!rst_n) begin
      bar_pos_q <= '0;
      bar_idx_q <= '0;
    end else if (!act_on) begin
      bar_pos_q <= '0;
      bar_idx_q <= '0;
    end else if (bar_pos_q == BAR_LAST) begin
      bar_pos_q <= '0;
      bar_idx_q <= bar_idx_q + 3'd1;
    end else begin
      bar_pos_q <= bar_pos_q + CNT_W'(1);
    end
  end

  assign test_sel = test_sel_q;
  assign bar_rgb  = {{COLOR_W{bar_idx_q[2]}}, {COLOR_W{bar_idx_q[1]}}, {COLOR_W{bar_idx_q[0]}}};
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign test_sel = 1'b0;
  assign bar_rgb  = '0;
`endif

  // FIFO is popped blindly during active stream video; it must ignore empty reads.
  assign pix_ready = act_on & run_q & ~test_sel;
  assign uf_set    = pix_ready & ~pix_valid;

  // Colour source; bars win over the stream since the stream is not popped then.
  always_comb begin
    rgb_d = '0;
    if (act_on && test_sel) begin
      rgb_d = bar_rgb;
    end else if (act_on && run_q && pix_valid) begin
      rgb_d = pix_data;
    end
  end

  // Output register stage, one cycle behind the raster counters.
  always_ff @(posedge pixel_clock or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= ~HS_ON;
      vsync_q       <= ~VS_ON;
      de_q          <= 1'b0;
      rgb_q         <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hs_on ? HS_ON : ~HS_ON;
      vsync_q       <= vs_on ? VS_ON : ~VS_ON;
      de_q          <= act_on;
      rgb_q         <= rgb_d;
      pix_x_q       <= act_on ? (h_cnt_q - H_ACT_BEG) : '0;
      pix_y_q       <= act_on ? (v_cnt_q - V_ACT_BEG) : '0;
      frame_start_q <= (h_cnt_q == '0) && (v_cnt_q == '0);
    end
  end

  // Sticky underflow flag; a set in the same cycle as a clear wins.
  always_ff @(posedge pixel_clock or negedge rst_n) begin
    if (!rst_n) begin
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= uf_set | (underflow_q & ~uf_clr);
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign r           = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign g           = rgb_q[2*COLOR_W-1:COLOR_W];
  assign b           = rgb_q[COLOR_W-1:0];
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = frame_start_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_vga_stream_out.sv
// Self-checking bench for vga_stream_out on a tiny 15x8 raster.
// A behavioural model derives raster position from the cycle index since reset
// and checks every output each cycle; literal checks pin the model.
module tb_vga_stream_out;

  localparam int H_SYNC = 3, H_BP = 2, H_ACT = 8, H_FP = 2;
  localparam int V_SYNC = 2, V_BP = 1, V_ACT = 4, V_FP = 1;
  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int F_TOT = H_TOT * V_TOT;
  localparam int CW = 4;
  localparam int CNT_W = 12;

  logic pixel_clock = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b0;
  logic test_mode = 1'b0;
  logic pix_valid = 1'b0;
  logic uf_clr = 1'b0;
  logic [3*CW-1:0] pix_data = '0;
  logic pix_ready, hsync, vsync, de, frame_start, underflow;
  logic [CW-1:0] r, g, b;
  logic [CNT_W-1:0] pix_x, pix_y;

  vga_stream_out #(
    .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACT(H_ACT), .H_FP(H_FP),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACT(V_ACT), .V_FP(V_FP),
    .HS_POL(0), .VS_POL(0), .COLOR_W(CW), .CNT_W(CNT_W)
  ) dut (
    .pixel_clock(pixel_clock), .rst_n(rst_n), .enable(enable), .test_mode(test_mode),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .uf_clr(uf_clr),
    .hsync(hsync), .vsync(vsync), .de(de), .r(r), .g(g), .b(b),
    .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start), .underflow(underflow)
  );

  always #5 pixel_clock = ~pixel_clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: cycle index since reset release, frame-latched controls, expectations.
  int cyc = 0;
  bit run_m, ts_m, uf_m;
  bit e_hs, e_vs, e_de, e_fs, e_uf;
  logic [3*CW-1:0] e_rgb;
  int e_x, e_y;
  int w_hs, w_vs, w_de, w_fs, w_pop;
  int last_hs = 0, last_vs = 0, last_de = 0, last_fs = 0, last_pop = 0;
  bit pop_seen = 0;

  // Compare process: inputs are stable at the falling edge.
  always @(negedge pixel_clock) begin : cmp
    int h, v, x, k;
    bit act, rdy;
    if (!rst_n) begin
      chk("rst_hsync", 32'(hsync), 32'd1);
      chk("rst_vsync", 32'(vsync), 32'd1);
      chk("rst_de", 32'(de), 32'd0);
      chk("rst_rgb", 32'({r, g, b}), 32'd0);
      chk("rst_pix_x", 32'(pix_x), 32'd0);
      chk("rst_pix_y", 32'(pix_y), 32'd0);
      chk("rst_frame_start", 32'(frame_start), 32'd0);
      chk("rst_underflow", 32'(underflow), 32'd0);
      chk("rst_pix_ready", 32'(pix_ready), 32'd0);
      cyc = 0; run_m = 0; ts_m = 0; uf_m = 0; pop_seen = 0;
      e_hs = 1; e_vs = 1; e_de = 0; e_fs = 0; e_uf = 0; e_rgb = '0; e_x = 0; e_y = 0;
      w_hs = 0; w_vs = 0; w_de = 0; w_fs = 0; w_pop = 0;
    end else begin
      // Outputs now on the pins belong to raster position cyc-1.
      chk("hsync", 32'(hsync), 32'(e_hs));
      chk("vsync", 32'(vsync), 32'(e_vs));
      chk("de", 32'(de), 32'(e_de));
      chk("rgb", 32'({r, g, b}), 32'(e_rgb));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
      chk("underflow", 32'(underflow), 32'(e_uf));
      if (e_de) begin
        chk("pix_x", 32'(pix_x), 32'(e_x));
        chk("pix_y", 32'(pix_y), 32'(e_y));
      end
      h = cyc % H_TOT;
      v = (cyc / H_TOT) % V_TOT;
      act = (h >= H_SYNC + H_BP) && (h < H_SYNC + H_BP + H_ACT) &&
            (v >= V_SYNC + V_BP) && (v < V_SYNC + V_BP + V_ACT);
      rdy = act && run_m && !ts_m;
      chk("pix_ready", 32'(pix_ready), 32'(rdy));
      pop_seen = pix_ready;
      if (!hsync) w_hs++;
      if (!vsync) w_vs++;
      if (de) w_de++;
      if (frame_start) w_fs++;
      if (pix_ready) w_pop++;
      x = h - (H_SYNC + H_BP);
      e_hs = !(h < H_SYNC);
      e_vs = !(v < V_SYNC);
      e_de = act;
      e_fs = (cyc % F_TOT == 0);
      e_x = x;
      e_y = v - (V_SYNC + V_BP);
      if (act && ts_m) begin
        k = x / (H_ACT / 8);
        e_rgb = {((k & 4) != 0) ? 4'hF : 4'h0, ((k & 2) != 0) ? 4'hF : 4'h0,
                 ((k & 1) != 0) ? 4'hF : 4'h0};
      end else if (act && run_m && pix_valid) begin
        e_rgb = pix_data;
      end else begin
        e_rgb = '0;
      end
      if (rdy && !pix_valid) uf_m = 1;
      else if (uf_clr) uf_m = 0;
      e_uf = uf_m;
      if (cyc % F_TOT == F_TOT - 1) begin
        run_m = enable;
`ifdef VGA_TEST_PATTERN_EN
        ts_m = test_mode;
`else
        ts_m = 0;
`endif
        last_hs = w_hs; last_vs = w_vs; last_de = w_de; last_fs = w_fs; last_pop = w_pop;
        w_hs = 0; w_vs = 0; w_de = 0; w_fs = 0; w_pop = 0;
      end
      cyc++;
    end
  end

  bit inc_mode = 0;
  logic [3*CW-1:0] data_cnt = '0;

  // Advance one cycle; inputs change 2 time units after the rising edge.
  task automatic step();
    @(posedge pixel_clock);
    #2;
    if (inc_mode) begin
      if (pop_seen) data_cnt = data_cnt + 12'd1;
      pix_data = data_cnt;
    end else begin
      pix_data = 12'($urandom);
    end
  endtask

  task automatic wait_cyc(input int target);
    int n;
    n = 0;
    while (cyc != target && n < 5000) begin
      step();
      n++;
    end
    chk("wait_cyc", 32'(cyc), 32'(target));
  endtask

  task automatic wait_mod(input int m);
    int n;
    n = 0;
    step();
    while ((cyc % F_TOT) != m && n < 1000) begin
      step();
      n++;
    end
    chk("wait_mod", 32'(cyc % F_TOT), 32'(m));
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!pix_ready && n < 500) begin
      step();
      n++;
    end
    chk("wait_ready", 32'(pix_ready), 32'd1);
  endtask

  logic [3*CW-1:0] bar_tab [8];

  initial begin
    bar_tab = '{12'h000, 12'h00F, 12'h0F0, 12'h0FF, 12'hF00, 12'hF0F, 12'hFF0, 12'hFFF};
    #1 rst_n = 1'b0;
    repeat (3) @(posedge pixel_clock);
    #2 rst_n = 1'b1;
    pix_valid = 1'b1;

    // Idle raster with enable low: sync/de shape, no pops.
    wait_cyc(2 * F_TOT);
    chk("lit_hs_low", 32'(last_hs), 32'd24);
    chk("lit_vs_low", 32'(last_vs), 32'd30);
    chk("lit_de_high", 32'(last_de), 32'd32);
    chk("lit_idle_pops", 32'(last_pop), 32'd0);
    chk("lit_fs_per_frame", 32'(last_fs), 32'd1);

    // Enable mid-frame: current frame stays dark, next one streams.
    wait_cyc(2 * F_TOT + 30);
    enable = 1'b1;
    inc_mode = 1;
    wait_cyc(3 * F_TOT);
    chk("lit_enable_frame_pops", 32'(last_pop), 32'd0);
    wait_cyc(4 * F_TOT);
    chk("lit_stream_pops", 32'(last_pop), 32'd32);

    // Underflow: single missing pixel, set/clear collision, clear alone.
    wait_ready();
    pix_valid = 1'b0;
    step();
    pix_valid = 1'b1;
    chk("lit_uf_rgb", 32'({r, g, b}), 32'd0);
    chk("lit_uf_set", 32'(underflow), 32'd1);
    repeat (20) step();
    chk("lit_uf_sticky", 32'(underflow), 32'd1);
    wait_ready();
    pix_valid = 1'b0;
    uf_clr = 1'b1;
    step();
    pix_valid = 1'b1;
    uf_clr = 1'b0;
    chk("lit_uf_set_wins", 32'(underflow), 32'd1);
    uf_clr = 1'b1;
    step();
    uf_clr = 1'b0;
    chk("lit_uf_cleared", 32'(underflow), 32'd0);

    // Disable mid-frame: that frame completes, the next is empty.
    wait_mod(60);
    enable = 1'b0;
    wait_mod(0);
    chk("lit_finish_frame_pops", 32'(last_pop), 32'd32);
    wait_mod(0);
    chk("lit_off_frame_pops", 32'(last_pop), 32'd0);
    chk("lit_off_frame_fs", 32'(last_fs), 32'd1);

    // Asynchronous reset at h=5, v=4 during a streaming frame.
    enable = 1'b1;
    wait_mod(0);
    wait_mod(0);
    wait_mod(4 * H_TOT + 5);
    chk("lit_pre_reset_ready", 32'(pix_ready), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("lit_async_hsync", 32'(hsync), 32'd1);
    chk("lit_async_vsync", 32'(vsync), 32'd1);
    chk("lit_async_de", 32'(de), 32'd0);
    chk("lit_async_rgb", 32'({r, g, b}), 32'd0);
    chk("lit_async_fs", 32'(frame_start), 32'd0);
    chk("lit_async_pix_ready", 32'(pix_ready), 32'd0);
    repeat (2) @(posedge pixel_clock);
    #2 rst_n = 1'b1;
    step();
    chk("lit_restart_fs", 32'(frame_start), 32'd1);
    chk("lit_restart_hsync", 32'(hsync), 32'd0);
    chk("lit_restart_vsync", 32'(vsync), 32'd0);

    // Random traffic against the model.
    inc_mode = 0;
    for (int i = 0; i < 6 * F_TOT; i++) begin
      pix_valid = ($urandom_range(0, 9) != 0);
      uf_clr = ($urandom_range(0, 19) == 0);
      if (i % 40 == 0) begin
        enable = 1'($urandom);
        test_mode = 1'($urandom);
      end
      step();
    end
    pix_valid = 1'b1;
    uf_clr = 1'b0;

`ifdef VGA_TEST_PATTERN_EN
    // Colour bars override the stream even with enable high.
    test_mode = 1'b1;
    enable = 1'b1;
    wait_mod(0);
    wait_mod(0);
    for (int i = 0; i < F_TOT; i++) begin
      step();
      chk("lit_bar_pix_ready", 32'(pix_ready), 32'd0);
      if (de) chk("lit_bar_rgb", 32'({r, g, b}), 32'(bar_tab[pix_x[2:0]]));
    end
    chk("lit_bar_frame_pops", 32'(last_pop), 32'd0);
`endif

    test_mode = 1'b0;
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
